// File: rtl/aes_block_pkg.sv
// Shared defaults and types for the AES block buffer.
package aes_block_pkg;

   localparam int unsigned AES_WIDTH      = 32;
   localparam int unsigned AES_WORDS      = 4;
   localparam int unsigned AES_DEPTH      = 8;
   localparam int unsigned AES_BLOCK_BITS = 128;

   typedef logic [AES_WIDTH-1:0] row_t;

endpackage

// File: rtl/aes_block_fifo.sv
// Word-loaded, block-unloaded circular buffer feeding the AES datapath.
// Words are assembled into WORDS-word blocks in one of DEPTH slots; each
// complete block is presented in parallel with a valid/ready handshake.
module aes_block_fifo
   import aes_block_pkg::*;
#(
   parameter int unsigned WIDTH = AES_WIDTH,
   parameter int unsigned WORDS = AES_WORDS,
   parameter int unsigned DEPTH = AES_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_word,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORDS*WIDTH-1:0]   out_block,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     partial
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned CW = PW + 1;

   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH][WORDS];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [CW-1:0] count_q,  count_d;

   logic push;
   logic pop;
   logic blk_done;

   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);
   assign partial   = (wr_idx_q != '0);
   assign count     = count_q;

   // A flush discards any handshake seen in the same cycle.
   assign push     = in_valid && in_ready && !flush;
   assign pop      = out_valid && out_ready && !flush;
   assign blk_done = push && (wr_idx_q == LAST_IDX);

   // Word storage; intentionally not reset, stale contents are masked by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q][wr_idx_q] <= in_word;
      end
   end

   // Head block read combinationally from the registered array.
   always_comb begin
      out_block = '0;
      for (int unsigned k = 0; k < WORDS; k++) begin
         out_block[k*WIDTH +: WIDTH] = mem_q[rd_ptr_q][k];
      end
   end

   // Pointer, word-index and occupancy next state; flush clears everything.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      wr_idx_d = wr_idx_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         wr_idx_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            if (blk_done) begin
               wr_idx_d = '0;
               wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
               wr_idx_d = wr_idx_q + IW'(1);
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         unique case ({blk_done, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         wr_idx_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_idx_q <= wr_idx_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_aes_block_fifo.sv
// Scoreboard bench for aes_block_fifo: stimulus queues expected blocks,
// a monitor pops and compares them on every output handshake.
module tb_aes_block_fifo;
   import aes_block_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   row_t         in_word = '0;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;
   logic [3:0]   count;
   logic         partial;

   int           or_mode = 0;   // 0: out_ready low, 1: high, 2: random
   logic         rnd_q = 1'b0;
   int           checks = 0;
   int           failures = 0;
   logic [127:0] sb[$];

   assign out_ready = (or_mode == 1) || ((or_mode == 2) && rnd_q);

   aes_block_fifo #(.WIDTH(32), .WORDS(4), .DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_block (out_block),
      .count     (count),
      .partial   (partial)
   );

   initial forever #5 clk = ~clk;

   // Random stall source, updated well away from both clock edges.
   initial forever begin
      @(posedge clk);
      #2;
      rnd_q = 1'($urandom_range(0, 1));
   end

   function automatic row_t word_of(input int b, input int k);
      logic [7:0]  bb;
      logic [7:0]  kk;
      logic [15:0] mix;
      bb  = 8'(b);
      kk  = 8'(k);
      mix = 16'(b * 257 + k);
      return {bb ^ 8'hB0, kk, mix};
   endfunction

   function automatic logic [127:0] blk_of(input int b);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) r[k*32 +: 32] = word_of(b, k);
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted output block must match the scoreboard head.
   initial forever begin
      @(negedge clk);
      if (!rst && !flush && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_underflow: got block %h expected no block", out_block);
         end else begin
            chk("pop_block", out_block, sb.pop_front());
         end
      end
   end

   task automatic push_word(input row_t w);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_word  = w;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL push_timeout: got in_ready=0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic push_block(input int b);
      sb.push_back(blk_of(b));
      for (int k = 0; k < 4; k++) push_word(word_of(b, k));
   endtask

   task automatic drain();
      int n;
      n = 0;
      or_mode = 1;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      or_mode = 0;
      chk("drain_empty", 128'(sb.size()), 128'd0);
      chk("drain_count", 128'(count), 128'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_count", 128'(count), 128'd0);
      chk("rst_partial", 128'(partial), 128'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single block with hand-computed parallel image
      sb.push_back(128'hCCDDEEFF8899AABB4455667700112233);
      push_word(32'h00112233);
      chk("single_partial", 128'(partial), 128'd1);
      push_word(32'h44556677);
      push_word(32'h8899AABB);
      push_word(32'hCCDDEEFF);
      chk("single_valid", 128'(out_valid), 128'd1);
      chk("single_count", 128'(count), 128'd1);
      chk("single_partial0", 128'(partial), 128'd0);
      chk("single_block", out_block, 128'hCCDDEEFF8899AABB4455667700112233);
      drain();

      // Fill to full, held word refused, one pop reopens input
      for (int b = 1; b <= 8; b++) push_block(b);
      chk("full_count", 128'(count), 128'd8);
      chk("full_in_ready", 128'(in_ready), 128'd0);
      in_valid = 1'b1;
      in_word  = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      #1;
      chk("full_hold_count", 128'(count), 128'd8);
      chk("full_hold_partial", 128'(partial), 128'd0);
      in_valid = 1'b0;
      or_mode = 1;
      @(posedge clk);
      #1;
      or_mode = 0;
      chk("unfull_in_ready", 128'(in_ready), 128'd1);
      chk("unfull_count", 128'(count), 128'd7);
      chk("unfull_head", out_block, blk_of(2));
      drain();

      // Wrap-around streaming with random back-pressure
      or_mode = 2;
      for (int b = 10; b < 30; b++) push_block(b);
      drain();

      // Final word of block 4 accepted in the cycle block 1 is popped
      for (int b = 50; b < 53; b++) push_block(b);
      for (int k = 0; k < 3; k++) push_word(word_of(53, k));
      chk("sim_pre_count", 128'(count), 128'd3);
      sb.push_back(blk_of(53));
      in_valid = 1'b1;
      in_word  = word_of(53, 3);
      or_mode  = 1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      or_mode  = 0;
      chk("sim_count", 128'(count), 128'd3);
      chk("sim_head", out_block, blk_of(51));
      drain();

      // Flush overriding concurrent load and unload
      push_block(60);
      push_block(61);
      push_word(word_of(62, 0));
      push_word(word_of(62, 1));
      flush    = 1'b1;
      in_valid = 1'b1;
      in_word  = 32'h0BADF00D;
      or_mode  = 1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      or_mode  = 0;
      sb.delete();
      chk("flush_count", 128'(count), 128'd0);
      chk("flush_partial", 128'(partial), 128'd0);
      chk("flush_out_valid", 128'(out_valid), 128'd0);
      push_block(70);
      chk("flush_new_count", 128'(count), 128'd1);
      chk("flush_new_block", out_block, blk_of(70));
      drain();

      // Asynchronous reset mid-block
      push_block(80);
      push_word(word_of(81, 0));
      push_word(word_of(81, 1));
      chk("pre_rst_partial", 128'(partial), 128'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_in_ready", 128'(in_ready), 128'd1);
      chk("arst_out_valid", 128'(out_valid), 128'd0);
      chk("arst_count", 128'(count), 128'd0);
      chk("arst_partial", 128'(partial), 128'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_block(90);
      chk("post_rst_block", out_block, blk_of(90));
      chk("post_rst_count", 128'(count), 128'd1);
      drain();

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_block_fifo.md
# aes_block_fifo

Parametrised block buffer that feeds the AES datapath. A host or test harness loads it one word at a time. It assembles WORDS-word state blocks in a circular store of DEPTH blocks and presents each complete block in parallel, with a valid/ready handshake. It generalises the fixed 4×32-bit, free-running-pointer block memory with:
- real write storage
- back-pressure
- occupancy tracking
- flush

## Interface
- WIDTH, 32, bits per word (row)
- WORDS, 4, words per block; block = WORDS*WIDTH bits
- DEPTH, 8, block slots; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of pointers, count and partial block
- in_valid  in  1  in_word valid
- in_ready  out  1  a word is accepted when in_valid && in_ready
- in_word  in  WIDTH  word to load; first word of a block is row0
- out_valid  out  1  a complete block is available
- out_ready  in  1  block is consumed when out_valid && out_ready
- out_block  out  WORDS*WIDTH  head block; row k at bits [k*WIDTH +: WIDTH]
- count  out  $clog2(DEPTH)+1  number of complete blocks held
- partial  out  1  at least one word of the next block has been accepted

## Operation
- **Storage:** DEPTH×WORDS array of WIDTH-bit words. The array is not reset.
- **State:**
  - wr_ptr: block slot being filled, $clog2(DEPTH) bits.
  - wr_idx: next word index, $clog2(WORDS) bits (minimum 1).
  - rd_ptr: head slot.
  - count.
- **Load:**
  - An accepted word is written to mem[wr_ptr][wr_idx], then wr_idx increments.
  - When wr_idx == WORDS-1 at acceptance: wr_idx ← 0, wr_ptr ← wr_ptr+1 (wraps mod DEPTH), and count increments.
- **Unload:**
  - out_block = mem[rd_ptr], read combinationally from the registered array.
  - On handshake: rd_ptr ← rd_ptr+1 (wraps), count decrements.
- **Simultaneous** final-word push and pop in the same cycle: count unchanged, both pointers advance.
- **Flow control:**
  - in_ready = (count != DEPTH). The slot being filled is always free while count < DEPTH.
  - out_valid = (count != 0).
  - partial = (wr_idx != 0).
- **Flush:**
  - Has priority over load and unload in the same cycle.
  - Sets wr_ptr, rd_ptr, wr_idx and count to 0. Any handshake in that cycle is discarded.
  - Memory contents are unchanged.
- **Reset (asynchronous):** same clears as flush. Resulting outputs: in_ready=1, out_valid=0, count=0, partial=0. out_block shows stale or X memory and must be ignored while out_valid=0.
- **Arithmetic:** pointer increments wrap naturally at power-of-two DEPTH. count never exceeds DEPTH and never goes below 0; the handshake guarantees this.
- **Assertion-level error:** bench asserts no push while full and no pop while empty.

## Timing
- **Word-to-block latency:** the block becomes visible (out_valid=1, count+1) on the clock edge that accepts its last word. It is observable the cycle after that word's handshake.
- **Pop:** out_block advances to the next slot's contents on the same edge that consumes the head. New data is visible the following cycle.
- **Full → not full:**
  - A pop at count=DEPTH raises in_ready the next cycle.
  - No same-cycle push bypass when full.
- **Empty → not empty:** no same-cycle fall-through. A word completing a block cannot be popped in its own acceptance cycle.
- **Throughput:** one word per cycle in; one block per cycle out.
- **Reset mid-block:** discards the partially loaded block with no partial output.

## Structure
- **Package aes_block_pkg:**
  - default WIDTH/WORDS/DEPTH constants.
  - AES_BLOCK_BITS = 128.
  - a row_t typedef (logic [WIDTH-1:0]).
- All control lives in one module, so no sub-module is needed. The count/pointer logic may optionally be split into aes_block_fifo_ctrl. The storage array stays in the top module.

## Test plan
- **Reset:** assert rst mid-stream → in_ready=1, out_valid=0, count=0, partial=0 immediately (asynchronous).
- **Single block:** load 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with out_ready=0.
  - partial=1 after the 1st word.
  - After the 4th word: out_valid=1, count=1, out_block=0xCCDDEEFF8899AABB4455667700112233.
- **Fill to full:** load 8 blocks with out_ready=0 → count=8, in_ready=0. A 33rd word held valid is not accepted. One pop → in_ready=1 next cycle, count=7.
- **Wrap-around:** stream 20 blocks with random out_ready stalls → blocks pop in order with exact contents; pointers wrap at 8.
- **Simultaneous push/pop:** count=3; the final word of block 4 is accepted in the same cycle block 1 is popped → count stays 3, next out_block = block 2.
- **Flush:** after 2 full blocks plus 2 words, flush together with in_valid and out_ready high → count=0, partial=0, out_valid=0. The next 4 loaded words form a correct new block in slot 0.
